systolic_gemm_tile: RTL and testbench
=====================================

// Module: systolic_gemm_tile
// PURPOSE
//  Parametrised ROWS x COLS output-stationary systolic GEMM tile: C = A(ROWSxK) * B(KxCOLS).
//  Adds internal input skew, a valid/ready operand stream, a programmable K depth and
//  clear/accumulate modes. Results drain serially, row-major, over a valid/ready port.
//  Sits between the operand fetch buffers and the result writeback/metrics logic.
// PARAMETERS
//  DATA_W  8    signed operand width (A and B elements)
//  ACC_W   32   signed accumulator/result width; must be >= 2*DATA_W
//  ROWS    4    PE rows (A rows / C rows), >= 1
//  COLS    4    PE columns (B columns / C columns), >= 1
//  K_MAX   256  max K beats per tile; KW = $clog2(K_MAX+1)
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous reset, active-low
//  start      in   1            pulse: begin a tile (honoured only in IDLE)
//  k_len      in   KW           K beats for this tile, sampled on start
//  acc_mode   in   1            sampled on start: 0 clear accumulators, 1 accumulate onto previous C
//  busy       out  1            high in any state other than IDLE
//  in_valid   in   1            operand beat valid
//  in_ready   out  1            tile accepts an operand beat
//  a_col      in   ROWS*DATA_W  A[r][k] in slice r
//  b_row      in   COLS*DATA_W  B[k][c] in slice c
//  out_valid  out  1            result element valid
//  out_ready  in   1            downstream accepts result
//  out_data   out  ACC_W        C[out_row][out_col]
//  out_row    out  max(1,$clog2(ROWS))   row index of out_data
//  out_col    out  max(1,$clog2(COLS))   column index of out_data
//  out_last   out  1            high with element (ROWS-1,COLS-1)
//  done       out  1            one-cycle pulse after the last result handshake
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->IDLE; all accumulators, skew regs, PE pipes, counters cleared;
//   busy, in_ready, out_valid, out_last, done = 0; out_data/out_row/out_col = 0.
//  FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
//   IDLE: start=1 and k_len in 1..K_MAX -> LOAD; latch k_len, acc_mode; acc_mode=0 zeroes
//    all accumulators on that edge. k_len=0 or k_len>K_MAX: start ignored, no done.
//   LOAD: in_ready=1. Beat accepted when in_valid&in_ready. On the k_len-th accepted beat
//    -> FLUSH (in_ready low from the next cycle). in_valid gaps are legal; each beat
//    carries its own valid token through skew and PE pipes, so bubbles never accumulate.
//   FLUSH: exactly ROWS+COLS-1 cycles, then DRAIN.
//   DRAIN: emits C row-major (0,0),(0,1)..(ROWS-1,COLS-1), one element per handshake.
//    out_valid held; out_data/row/col/last stable while out_valid&!out_ready.
//    Final handshake -> IDLE with done=1 for one cycle on the following cycle.
//  Skew/timing: A slice r delayed r cycles, B slice c delayed c cycles; a passes right,
//   b passes down, one register per PE. A beat accepted at edge E is accumulated by
//   PE(r,c) at edge E+r+c+1.
//  Arithmetic: signed DATA_W x DATA_W -> 2*DATA_W product, sign-extended to ACC_W;
//   accumulation wraps modulo 2^ACC_W (no saturation, no flag).
//  start while busy: ignored. in_valid outside LOAD: ignored.
//  Accumulators persist across tiles until reset or an acc_mode=0 start.
//  Reset mid-operation: immediate return to reset state; stale skew/PE data discarded.
// TESTING
//  1 ROWS=COLS=2; A=[1 2;3 4], B=[5 6;7 8], k_len=2, acc_mode=0 -> out 19,22,43,50
//    row-major, out_last on 50, done one cycle after the last handshake.
//  2 Default 4x4; A=I4, B=[1..16] row-major, k_len=4 -> C==B; busy high from start to done.
//  3 Test 1 with in_valid every other cycle and out_ready random 50% -> same results;
//    out_* stable during stalls; no extra or missing beats.
//  4 Test 1 repeated with acc_mode=1 -> 38,44,86,100; then acc_mode=0 -> 19,22,43,50.
//  5 ACC_W=16, ROWS=COLS=1: A=B=-128, k_len=2 -> -32768 (wrap); k_len=1 -> 16384.
//  6 Reset asserted mid-FLUSH -> all outputs 0 immediately; then an acc_mode=1 tile of
//    test 1 -> 19,22,43,50. start with k_len=0 and start during LOAD -> no effect.

Source files
------------

// File: rtl/systolic_gemm_tile.sv
// Output-stationary ROWS x COLS systolic GEMM tile: skewed operand stream in,
// row-major serial result drain out, with clear/accumulate tile modes.
module systolic_gemm_tile #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_MAX  = 256,
    localparam int KW = $clog2(K_MAX + 1),
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    input  logic                   acc_mode,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] a_col,
    input  logic [COLS*DATA_W-1:0] b_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data,
    output logic [RW-1:0]          out_row,
    output logic [CW-1:0]          out_col,
    output logic                   out_last,
    output logic                   done
);

    localparam int FW = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN
    } state_t;

    state_t state, next_state;

    logic [KW-1:0] k_len_q;
    logic [KW-1:0] k_cnt;
    logic [FW-1:0] flush_cnt;

    logic start_ok;
    logic beat;
    logic last_beat;
    logic flush_end;
    logic out_fire;
    logic drain_end;
    logic acc_clear;

    // Operands and valid tokens arriving at each PE, indexed r*COLS+c.
    logic [ROWS*COLS*DATA_W-1:0] a_in;
    logic [ROWS*COLS*DATA_W-1:0] b_in;
    logic [ROWS*COLS-1:0]        v_in;
    logic [ROWS*COLS*ACC_W-1:0]  acc_flat;

    assign start_ok  = start && (k_len != '0) && (k_len <= KW'(K_MAX));
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (k_cnt == (k_len_q - KW'(1)));
    assign flush_end = (flush_cnt == FW'(ROWS + COLS - 2));
    assign out_fire  = out_valid && out_ready;
    assign drain_end = out_fire && out_last;
    assign acc_clear = (state == IDLE) && start_ok && !acc_mode;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (out_row == RW'(ROWS - 1)) && (out_col == CW'(COLS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok)  next_state = LOAD;
            LOAD:    if (last_beat) next_state = FLUSH;
            FLUSH:   if (flush_end) next_state = DRAIN;
            DRAIN:   if (drain_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len_q   <= '0;
            k_cnt     <= '0;
            flush_cnt <= '0;
            out_row   <= '0;
            out_col   <= '0;
            done      <= 1'b0;
        end else begin
            done <= drain_end;
            if ((state == IDLE) && start_ok) begin
                k_len_q <= k_len;
                k_cnt   <= '0;
            end else if (beat) begin
                k_cnt <= last_beat ? '0 : k_cnt + KW'(1);
            end
            if (state == FLUSH) begin
                flush_cnt <= flush_end ? '0 : flush_cnt + FW'(1);
            end
            // Row-major walk; both counters return to zero after the last element.
            if (out_fire) begin
                if (out_col == CW'(COLS - 1)) begin
                    out_col <= '0;
                    out_row <= (out_row == RW'(ROWS - 1)) ? '0 : out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
            end
        end
    end

    // Row r of A sees r+1 register stages, so it meets B in PE(r,c) on edge E+r+c+1.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
        logic [DATA_W-1:0] sk [0:r];
        logic [r:0]        skv;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= r; s++) begin
                    sk[s] <= '0;
                end
                skv <= '0;
            end else begin
                sk[0]  <= a_col[r*DATA_W +: DATA_W];
                skv[0] <= beat;
                for (int s = 1; s <= r; s++) begin
                    sk[s]  <= sk[s-1];
                    skv[s] <= skv[s-1];
                end
            end
        end

        assign a_in[(r*COLS)*DATA_W +: DATA_W] = sk[r];
        assign v_in[r*COLS]                    = skv[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_skew_b
        logic [DATA_W-1:0] sk [0:c];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= c; s++) begin
                    sk[s] <= '0;
                end
            end else begin
                sk[0] <= b_row[c*DATA_W +: DATA_W];
                for (int s = 1; s <= c; s++) begin
                    sk[s] <= sk[s-1];
                end
            end
        end

        assign b_in[c*DATA_W +: DATA_W] = sk[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            localparam int IDX = r*COLS + c;

            logic signed [DATA_W-1:0]   a_op;
            logic signed [DATA_W-1:0]   b_op;
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W-1:0]    acc;

            assign a_op = a_in[IDX*DATA_W +: DATA_W];
            assign b_op = b_in[IDX*DATA_W +: DATA_W];
            assign prod = (2*DATA_W)'(a_op) * (2*DATA_W)'(b_op);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                end else if (acc_clear) begin
                    acc <= '0;
                end else if (v_in[IDX]) begin
                    acc <= acc + ACC_W'(prod);
                end
            end

            assign acc_flat[IDX*ACC_W +: ACC_W] = acc;

            if (c < COLS - 1) begin : g_pass_a
                logic [DATA_W-1:0] a_q;
                logic              v_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                        v_q <= 1'b0;
                    end else begin
                        a_q <= a_op;
                        v_q <= v_in[IDX];
                    end
                end

                assign a_in[(IDX+1)*DATA_W +: DATA_W] = a_q;
                assign v_in[IDX+1]                    = v_q;
            end

            if (r < ROWS - 1) begin : g_pass_b
                logic [DATA_W-1:0] b_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        b_q <= '0;
                    end else begin
                        b_q <= b_op;
                    end
                end

                assign b_in[(IDX+COLS)*DATA_W +: DATA_W] = b_q;
            end
        end
    end

    // Result is forced to zero whenever no element is being offered.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            if (out_valid && (out_row == RW'(i / COLS)) && (out_col == CW'(i % COLS))) begin
                out_data = acc_flat[i*ACC_W +: ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_systolic_gemm_tile.sv
// Scoreboard bench for systolic_gemm_tile: 2x2, 4x4 and 1x1/16-bit instances share the
// input stimulus; one instance at a time is observed and checked against a matrix model.
module tb_systolic_gemm_tile;

    localparam int KW = 9;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          acc_mode;
    logic          in_valid;
    logic          out_ready;
    logic [31:0]   a_bus;
    logic [31:0]   b_bus;

    logic        busy2, in_ready2, out_valid2, out_last2, done2;
    logic [31:0] out_data2;
    logic [0:0]  out_row2, out_col2;
    logic        busy4, in_ready4, out_valid4, out_last4, done4;
    logic [31:0] out_data4;
    logic [1:0]  out_row4, out_col4;
    logic        busy1, in_ready1, out_valid1, out_last1, done1;
    logic [15:0] out_data1;
    logic [0:0]  out_row1, out_col1;

    int          sel;
    logic        obs_busy, obs_in_ready, obs_valid, obs_last, obs_done;
    logic [31:0] obs_data;
    logic [1:0]  obs_row, obs_col;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int     mat_a [4][8];
    int     mat_b [8][4];
    longint model_c [4][4];
    exp_t   sb [$];

    systolic_gemm_tile #(.ROWS(2), .COLS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_mode(acc_mode),
        .busy(busy2), .in_valid(in_valid), .in_ready(in_ready2),
        .a_col(a_bus[15:0]), .b_row(b_bus[15:0]),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_row(out_row2), .out_col(out_col2), .out_last(out_last2), .done(done2)
    );

    systolic_gemm_tile dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_mode(acc_mode),
        .busy(busy4), .in_valid(in_valid), .in_ready(in_ready4),
        .a_col(a_bus), .b_row(b_bus),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_row(out_row4), .out_col(out_col4), .out_last(out_last4), .done(done4)
    );

    systolic_gemm_tile #(.ACC_W(16), .ROWS(1), .COLS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_mode(acc_mode),
        .busy(busy1), .in_valid(in_valid), .in_ready(in_ready1),
        .a_col(a_bus[7:0]), .b_row(b_bus[7:0]),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_row(out_row1), .out_col(out_col1), .out_last(out_last1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the instance under test onto one set of observation signals.
    always_comb begin
        obs_busy     = busy2;
        obs_in_ready = in_ready2;
        obs_valid    = out_valid2;
        obs_last     = out_last2;
        obs_done     = done2;
        obs_data     = out_data2;
        obs_row      = {1'b0, out_row2};
        obs_col      = {1'b0, out_col2};
        if (sel == 4) begin
            obs_busy     = busy4;
            obs_in_ready = in_ready4;
            obs_valid    = out_valid4;
            obs_last     = out_last4;
            obs_done     = done4;
            obs_data     = out_data4;
            obs_row      = out_row4;
            obs_col      = out_col4;
        end else if (sel == 1) begin
            obs_busy     = busy1;
            obs_in_ready = in_ready1;
            obs_valid    = out_valid1;
            obs_last     = out_last1;
            obs_done     = done1;
            obs_data     = {{16{out_data1[15]}}, out_data1};
            obs_row      = {1'b0, out_row1};
            obs_col      = {1'b0, out_col1};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 'h%0h, required 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_busy"},     64'(obs_busy),     64'd0);
        check({tag, "_in_ready"}, 64'(obs_in_ready), 64'd0);
        check({tag, "_valid"},    64'(obs_valid),    64'd0);
        check({tag, "_last"},     64'(obs_last),     64'd0);
        check({tag, "_done"},     64'(obs_done),     64'd0);
        check({tag, "_data"},     64'(obs_data),     64'd0);
        check({tag, "_row"},      64'(obs_row),      64'd0);
        check({tag, "_col"},      64'(obs_col),      64'd0);
    endtask

    task automatic clearModel();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                model_c[r][c] = 0;
    endtask

    task automatic clearMats();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) begin
                mat_a[r][k] = 0;
                mat_b[k][r] = 0;
            end
    endtask

    function automatic logic [31:0] wrapAcc(input longint v, input int acc_w);
        logic [63:0] t;
        t = v;
        if (acc_w == 16) return {{16{t[15]}}, t[15:0]};
        return t[31:0];
    endfunction

    task automatic pushExpect(input int rows, input int cols, input int k, input bit acc, input int acc_w);
        exp_t   e;
        longint s;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (!acc) model_c[r][c] = 0;
                s = 0;
                for (int kk = 0; kk < k; kk++) s += longint'(mat_a[r][kk]) * longint'(mat_b[kk][c]);
                model_c[r][c] += s;
                e.data = wrapAcc(model_c[r][c], acc_w);
                e.row  = 2'(r);
                e.col  = 2'(c);
                e.last = (r == rows - 1) && (c == cols - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clearModel();
    endtask

    task automatic applyStimulus(input int k, input bit acc, input int gap, input bit glitch);
        int guard;
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(k); acc_mode = acc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(obs_busy), 64'd1);
        check("in_ready_load", 64'(obs_in_ready), 64'd1);
        for (int kk = 0; kk < k; kk++) begin
            for (int r = 0; r < 4; r++) a_bus[r*8 +: 8] = 8'(mat_a[r][kk]);
            for (int c = 0; c < 4; c++) b_bus[c*8 +: 8] = 8'(mat_b[kk][c]);
            in_valid = 1'b1;
            if (glitch && kk == 0) begin
                start = 1'b1; k_len = KW'(1); acc_mode = 1'b0;
            end
            guard = 0;
            while (!obs_in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("in_ready_beat", 64'(obs_in_ready), 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            start = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        check("in_ready_flush", 64'(obs_in_ready), 64'd0);
        check("busy_flush", 64'(obs_busy), 64'd1);
    endtask

    task automatic checkOutput(input int n, input bit rnd);
        int   got = 0;
        int   guard = 0;
        bit   stalled = 1'b0;
        exp_t held;
        exp_t e;
        while (got < n && guard < 1000) begin
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            guard++;
            if (stalled) begin
                check("stall_valid", 64'(obs_valid), 64'd1);
                check("stall_hold", 64'({obs_data, obs_row, obs_col, obs_last}), 64'(held));
            end
            stalled = 1'b0;
            if (obs_valid) begin
                if (out_ready) begin
                    e = (sb.size() > 0) ? sb.pop_front() : '0;
                    check("out_data", 64'(obs_data), 64'(e.data));
                    check("out_row", 64'(obs_row), 64'(e.row));
                    check("out_col", 64'(obs_col), 64'(e.col));
                    check("out_last", 64'(obs_last), 64'(e.last));
                    check("done_during_drain", 64'(obs_done), 64'd0);
                    got++;
                end else begin
                    held = {obs_data, obs_row, obs_col, obs_last};
                    stalled = 1'b1;
                end
            end
        end
        check("drain_count", 64'(got), 64'(n));
        check("sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
        check("done_pulse", 64'(obs_done), 64'd1);
        check("busy_at_done", 64'(obs_busy), 64'd0);
        check("valid_at_done", 64'(obs_valid), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(obs_done), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic ignoredStart(input int k);
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(k); acc_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("ignored_busy", 64'(obs_busy), 64'd0);
        check("ignored_in_ready", 64'(obs_in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("ignored_done", 64'(obs_done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; acc_mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a_bus = '0; b_bus = '0;
        sel = 2;
        clearModel();
        clearMats();
        #12;
        checkZero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] 2x2 basic tile");
        mat_a[0][0] = 1; mat_a[0][1] = 2; mat_a[1][0] = 3; mat_a[1][1] = 4;
        mat_b[0][0] = 5; mat_b[0][1] = 6; mat_b[1][0] = 7; mat_b[1][1] = 8;
        pushExpect(2, 2, 2, 1'b0, 32);
        applyStimulus(2, 1'b0, 0, 1'b0);
        checkOutput(4, 1'b0);

        $display("[TB] 2x2 with input gaps and random out_ready");
        pushExpect(2, 2, 2, 1'b0, 32);
        applyStimulus(2, 1'b0, 1, 1'b0);
        checkOutput(4, 1'b1);

        $display("[TB] 2x2 accumulate then clear");
        pushExpect(2, 2, 2, 1'b1, 32);
        applyStimulus(2, 1'b1, 0, 1'b0);
        checkOutput(4, 1'b1);
        pushExpect(2, 2, 2, 1'b0, 32);
        applyStimulus(2, 1'b0, 0, 1'b0);
        checkOutput(4, 1'b0);

        $display("[TB] reset during flush");
        applyStimulus(2, 1'b1, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkZero("reset_mid_flush");
        clearModel();
        @(posedge clk); #1;
        rst_n = 1'b1;
        pushExpect(2, 2, 2, 1'b1, 32);
        applyStimulus(2, 1'b1, 0, 1'b1);
        checkOutput(4, 1'b0);

        $display("[TB] out-of-range starts leave accumulators alone");
        ignoredStart(0);
        ignoredStart(300);
        pushExpect(2, 2, 2, 1'b1, 32);
        applyStimulus(2, 1'b1, 0, 1'b0);
        checkOutput(4, 1'b0);

        $display("[TB] 4x4 identity times B");
        resetDut();
        sel = 4;
        clearMats();
        for (int r = 0; r < 4; r++) begin
            mat_a[r][r] = 1;
            for (int c = 0; c < 4; c++) mat_b[r][c] = r*4 + c + 1;
        end
        pushExpect(4, 4, 4, 1'b0, 32);
        applyStimulus(4, 1'b0, 0, 1'b0);
        checkOutput(16, 1'b1);

        $display("[TB] 1x1 16-bit wrap");
        resetDut();
        sel = 1;
        clearMats();
        mat_a[0][0] = -128; mat_a[0][1] = -128;
        mat_b[0][0] = -128; mat_b[1][0] = -128;
        pushExpect(1, 1, 2, 1'b0, 16);
        applyStimulus(2, 1'b0, 0, 1'b0);
        checkOutput(1, 1'b0);
        pushExpect(1, 1, 1, 1'b0, 16);
        applyStimulus(1, 1'b0, 0, 1'b0);
        checkOutput(1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
